// File: rtl/alu_writeback.sv
// Purpose: queue ALU results, apply RV64 W-op sign extension and commit them to a 32x64 register file.
// Latency: one cycle minimum from acceptance to commit; read ports are combinational with commit forwarding.
// Backpressure: alu_ready drops when the queue is full or the block is draining or dumping the register file.
module alu_writeback #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int REG_COUNT      = 32,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [BUS_DATA_WIDTH-1:0] alu_result,
    input  logic [5:0]                alu_control,
    input  logic [4:0]                rd,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    output logic [BUS_DATA_WIDTH-1:0] rs1_data,
    output logic [BUS_DATA_WIDTH-1:0] rs2_data,
    output logic                      rs_pending,
    input  logic                      end_of_cycle,
    output logic                      dump_valid,
    output logic [4:0]                dump_idx,
    output logic [BUS_DATA_WIDTH-1:0] dump_data,
    output logic                      dump_done,
    output logic                      illegal_op
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DUMP, DONE} state_t;

    state_t                    state, state_nxt;
    logic [BUS_DATA_WIDTH-1:0] regfile [REG_COUNT];
    logic [BUS_DATA_WIDTH-1:0] q_res   [FIFO_DEPTH];
    logic [5:0]                q_op    [FIFO_DEPTH];
    logic [4:0]                q_rd    [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr, slot_off;
    logic [CW-1:0]             count;
    logic [4:0]                idx;
    logic                      ready_en;
    logic                      full, empty, push, pop;
    logic                      cm_legal, cm_wr;
    logic [5:0]                cm_op;
    logic [4:0]                cm_rd;
    logic [BUS_DATA_WIDTH-1:0] cm_raw, cm_val;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // ready_en keeps the port closed until the first clock after reset release
    assign alu_ready = ready_en && (state == RUN) && !full;
    assign push      = alu_valid && alu_ready;
    assign pop       = ((state == RUN) || (state == DRAIN)) && !empty;
    assign cm_op     = q_op[rd_ptr];
    assign cm_rd     = q_rd[rd_ptr];
    assign cm_raw    = q_res[rd_ptr];
    assign cm_wr     = pop && cm_legal && (cm_rd != 5'd0);

    // Decode the head opcode: undefined ops are dropped, W ops sign-extend the low word
    always_comb begin
        cm_legal = 1'b1;
        cm_val   = cm_raw;
        if ((cm_op == 6'h00) || (cm_op == 6'h0A) || (cm_op == 6'h0B) || (cm_op >= 6'h2C)) begin
            cm_legal = 1'b0;
        end else if (((cm_op >= 6'h16) && (cm_op <= 6'h1E)) || ((cm_op >= 6'h27) && (cm_op <= 6'h2B))) begin
            cm_val = {{(BUS_DATA_WIDTH-32){cm_raw[31]}}, cm_raw[31:0]};
        end
    end

    // Queue storage and pointers; a push never lands in the same cycle as its own commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_res[i] <= '0;
                q_op[i]  <= '0;
                q_rd[i]  <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                q_res[wr_ptr] <= alu_result;
                q_op[wr_ptr]  <= alu_control;
                q_rd[wr_ptr]  <= rd;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Register file commit and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regfile[i] <= '0;
            end
            illegal_op <= 1'b0;
        end else begin
            if (cm_wr) begin
                regfile[cm_rd] <= cm_val;
            end
            if (pop && !cm_legal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    // Read ports: x0 is zero, a same-cycle commit wins over the stored value
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (cm_wr && (cm_rd == rs1_addr)) ? cm_val : regfile[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            rs2_data = (cm_wr && (cm_rd == rs2_addr)) ? cm_val : regfile[rs2_addr];
        end
    end

    // Flag reads that hit a queued destination which is not being committed this cycle
    always_comb begin
        rs_pending = 1'b0;
        slot_off   = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr;
            if (({1'b0, slot_off} < count) && !(pop && (slot_off == '0))) begin
                if (((rs1_addr != 5'd0) && (q_rd[i] == rs1_addr)) ||
                    ((rs2_addr != 5'd0) && (q_rd[i] == rs2_addr))) begin
                    rs_pending = 1'b1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: drain the queue, dump every register, pulse done, resume
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (end_of_cycle) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = DUMP;
            DUMP:    if (idx == 5'(REG_COUNT-1)) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Dump index walks the register file only while dumping and rests at zero otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (state == DUMP) begin
            idx <= idx + 5'd1;
        end else begin
            idx <= '0;
        end
    end

    // FSM outputs
    always_comb begin
        dump_valid = (state == DUMP);
        dump_done  = (state == DONE);
        dump_idx   = dump_valid ? idx : 5'd0;
        dump_data  = dump_valid ? regfile[idx] : '0;
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Purpose: randomized and directed check of alu_writeback against a queue/array reference model.
// Latency: model advances once per clock; outputs are compared 1-2 time units after the falling edge.
// Backpressure: the model decides acceptance from its own queue occupancy and mode.
module tb_alu_writeback;
    localparam int DEPTH = 2;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DUMP = 2, M_DONE = 3;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  op;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [63:0] alu_result;
    logic [5:0]  alu_control;
    logic [4:0]  rd;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        rs_pending;
    logic        end_of_cycle;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [63:0] dump_data;
    logic        dump_done;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    ent_t        mq[$];
    logic [63:0] mreg [32];
    bit          mill;
    bit          mready_en;
    int          mode;
    int          midx;

    alu_writeback #(.BUS_DATA_WIDTH(64), .REG_COUNT(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
        .alu_control(alu_control), .rd(rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs_pending(rs_pending), .end_of_cycle(end_of_cycle),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        int v;
        v = int'(op);
        return !((v == 0) || (v == 10) || (v == 11) || (v >= 44));
    endfunction

    function automatic logic [63:0] op_fmt(input logic [5:0] op, input logic [63:0] r);
        int v;
        v = int'(op);
        if (((v >= 22) && (v <= 30)) || ((v >= 39) && (v <= 43)))
            return {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mill      = 1'b0;
        mready_en = 1'b0;
        mode      = M_RUN;
        midx      = 0;
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] a, input bit pop, input ent_t h);
        if (a == 5'd0) return '0;
        if (pop && op_legal(h.op) && (h.rd == a)) return op_fmt(h.op, h.res);
        return mreg[a];
    endfunction

    // Called just after a falling edge with inputs already driven: check, clock, advance model.
    task automatic cycle();
        bit   pop, push, ready, pend;
        ent_t h, e;
        int   old_size;
        h        = '0;
        old_size = mq.size();
        pop      = ((mode == M_RUN) || (mode == M_DRAIN)) && (old_size > 0);
        if (pop) h = mq[0];
        ready = mready_en && (mode == M_RUN) && (old_size < DEPTH);
        pend  = 1'b0;
        for (int i = (pop ? 1 : 0); i < old_size; i++) begin
            if (((rs1_addr != 0) && (mq[i].rd == rs1_addr)) || ((rs2_addr != 0) && (mq[i].rd == rs2_addr)))
                pend = 1'b1;
        end
        #1;
        check("alu_ready", 64'(alu_ready), 64'(ready));
        check("rs1_data", rs1_data, exp_read(rs1_addr, pop, h));
        check("rs2_data", rs2_data, exp_read(rs2_addr, pop, h));
        check("rs_pending", 64'(rs_pending), 64'(pend));
        check("dump_valid", 64'(dump_valid), 64'(mode == M_DUMP));
        check("dump_idx", 64'(dump_idx), (mode == M_DUMP) ? 64'(midx) : 64'd0);
        check("dump_data", dump_data, (mode == M_DUMP) ? mreg[midx] : 64'd0);
        check("dump_done", 64'(dump_done), 64'(mode == M_DONE));
        check("illegal_op", 64'(illegal_op), 64'(mill));
        push = alu_valid && ready;
        e.res = alu_result;
        e.op  = alu_control;
        e.rd  = rd;
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            if (!op_legal(h.op)) mill = 1'b1;
            else if (h.rd != 0) mreg[h.rd] = op_fmt(h.op, h.res);
        end
        if (push) mq.push_back(e);
        case (mode)
            M_RUN:   if (end_of_cycle) mode = M_DRAIN;
            M_DRAIN: if (old_size == 0) begin mode = M_DUMP; midx = 0; end
            M_DUMP:  if (midx == 31) mode = M_DONE; else midx++;
            default: begin mode = M_RUN; midx = 0; end
        endcase
        mready_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [63:0] res, input logic [4:0] d);
        alu_valid   = v;
        alu_control = op;
        alu_result  = res;
        rd          = d;
    endtask

    initial begin
        int          beats, dones, k;
        logic [4:0]  last_rd;
        reset = 1'b0;
        drive(0, 6'h00, 64'h0, 5'd0);
        rs1_addr     = 5'd0;
        rs2_addr     = 5'd0;
        end_of_cycle = 1'b0;
        model_reset();

        // reset state
        #3;
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_idx", 64'(dump_idx), 64'd0);
        check("rst_dump_done", 64'(dump_done), 64'd0);
        check("rst_illegal", 64'(illegal_op), 64'd0);
        check("rst_pending", 64'(rs_pending), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // idle: all registers read zero
        for (int i = 0; i < 16; i++) begin
            rs1_addr = 5'(2*i);
            rs2_addr = 5'(2*i+1);
            cycle();
        end
        #1 check("ready_after_reset", 64'(alu_ready), 64'd1);
        @(negedge clk);

        // addw sign-extends and forwards on the commit cycle
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        drive(1, 6'h1A, 64'h0000_0000_8000_0001, 5'd5);
        cycle();
        drive(0, 6'h00, 64'h0, 5'd0);
        #1 check("addw_forward", rs1_data, 64'hFFFF_FFFF_8000_0001);
        cycle();
        #1 check("addw_stored", rs1_data, 64'hFFFF_FFFF_8000_0001);
        @(negedge clk);

        // write to x0 discarded, undefined opcode sets the sticky flag
        rs1_addr = 5'd0;
        drive(1, 6'h0C, 64'h1234, 5'd0);
        cycle();
        drive(1, 6'h30, 64'hDEAD, 5'd3);
        rs2_addr = 5'd3;
        cycle();
        drive(0, 6'h00, 64'h0, 5'd0);
        cycle();
        #1 check("x0_zero", rs1_data, 64'd0);
        check("illegal_set", 64'(illegal_op), 64'd1);
        check("illegal_nowrite", rs2_data, 64'd0);
        @(negedge clk);

        // held valid with two back-to-back pushes, reading the second destination
        rs2_addr = 5'd9;
        drive(1, 6'h01, 64'h1111, 5'd7);
        cycle();
        drive(1, 6'h20, 64'h2222_0000_9999, 5'd9);
        cycle();
        drive(0, 6'h00, 64'h0, 5'd0);
        for (int i = 0; i < 3; i++) cycle();
        #1 check("second_rd", rs2_data, 64'h2222_0000_9999);
        check("illegal_sticky", 64'(illegal_op), 64'd1);
        @(negedge clk);

        // randomized traffic with occasional dumps
        last_rd = 5'd1;
        for (int n = 0; n < 400; n++) begin
            alu_valid    = ($urandom_range(0, 9) < 7);
            alu_control  = 6'($urandom_range(0, 63));
            alu_result   = {$urandom, $urandom};
            rd           = 5'($urandom_range(0, 31));
            rs1_addr     = $urandom_range(0, 1) ? last_rd : 5'($urandom_range(0, 31));
            rs2_addr     = 5'($urandom_range(0, 31));
            end_of_cycle = ($urandom_range(0, 49) == 0);
            if (alu_valid) last_rd = rd;
            cycle();
        end
        end_of_cycle = 1'b0;
        drive(0, 6'h00, 64'h0, 5'd0);
        while (mode != M_RUN) cycle();

        // directed dump: one entry in flight when end_of_cycle arrives
        drive(1, 6'h1C, 64'h0000_0001_7FFF_FFFF, 5'd31);
        end_of_cycle = 1'b1;
        cycle();
        drive(0, 6'h00, 64'h0, 5'd0);
        end_of_cycle = 1'b0;
        beats = 0;
        dones = 0;
        k     = 0;
        while ((dones == 0) && (k < 80)) begin
            #1;
            if (dump_valid) beats++;
            if (dump_done) dones++;
            cycle();
            k++;
        end
        check("dump_beats", 64'(beats), 64'd32);
        check("dump_done_count", 64'(dones), 64'd1);
        check("x31_value", mreg[31], 64'h0000_0000_7FFF_FFFF);
        #1 check("ready_after_dump", 64'(alu_ready), 64'd1);
        @(negedge clk);

        // reset in the middle of a dump
        rs1_addr     = 5'd31;
        end_of_cycle = 1'b1;
        cycle();
        end_of_cycle = 1'b0;
        k = 0;
        while (!((mode == M_DUMP) && (midx == 10)) && (k < 80)) begin
            cycle();
            k++;
        end
        #1 check("dump_at_10", 64'(dump_idx), 64'd10);
        #1 reset = 1'b0;
        #1;
        check("abort_dump_valid", 64'(dump_valid), 64'd0);
        check("abort_dump_idx", 64'(dump_idx), 64'd0);
        check("abort_dump_done", 64'(dump_done), 64'd0);
        check("abort_reg_clear", rs1_data, 64'd0);
        check("abort_ready", 64'(alu_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            rs1_addr = 5'(i % 32);
            rs2_addr = 5'((i + 7) % 32);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
